// File: rtl/frogger_pkg.sv
// Shared frogger constants: active area, frog geometry, spawn point,
// controller state encoding and one-hot hop directions.
package frogger_pkg;

   localparam int H_ACTIVE    = 640;
   localparam int V_ACTIVE    = 480;
   localparam int FROG_SIZE   = 32;
   localparam int DEF_START_X = 320;
   localparam int DEF_START_Y = 448;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COOLDOWN = 2'd1,
      ST_DEAD     = 2'd2
   } frog_state_t;

   typedef logic [3:0] dir_t;

   localparam dir_t DIR_NONE  = 4'b0000;
   localparam dir_t DIR_UP    = 4'b0001;
   localparam dir_t DIR_DOWN  = 4'b0010;
   localparam dir_t DIR_LEFT  = 4'b0100;
   localparam dir_t DIR_RIGHT = 4'b1000;

   // Same-cycle presses resolve up > down > left > right.
   function automatic dir_t dir_prio(input logic up, input logic down,
                                     input logic left, input logic right);
      if (up)         return DIR_UP;
      else if (down)  return DIR_DOWN;
      else if (left)  return DIR_LEFT;
      else if (right) return DIR_RIGHT;
      else            return DIR_NONE;
   endfunction

endpackage

// File: rtl/frog_controller_if.sv
// Player/game-logic side of the frog controller: raw buttons, frame tick,
// collision level in; frog position and event pulses out.
interface frog_controller_if;

   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       frame_tick;
   logic       collision;
   logic [9:0] frog_x;
   logic [9:0] frog_y;
   logic       hop_pulse;
   logic       row_advance;
   logic       dead;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, frame_tick, collision,
      input  frog_x, frog_y, hop_pulse, row_advance, dead
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, frame_tick, collision,
      output frog_x, frog_y, hop_pulse, row_advance, dead
   );

endinterface

// File: rtl/frog_controller_button_edge.sv
// Two-flop synchronizer for one raw button followed by a rising-edge pulse.
module button_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_rise
);

   logic sync_p0;
   logic sync_p1;
   logic sync_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= btn_in;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   // sync_p2 only remembers the previous synchronized level for edge detection.
   assign btn_rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/frog_controller.sv
// Frog position owner: buttons become pending hops, applied once per frame
// tick with clamping, hop cooldown and a timed death/respawn sequence.
module frog_controller
   import frogger_pkg::*;
#(
   parameter int STEP         = FROG_SIZE,
   parameter int MAX_X        = H_ACTIVE - FROG_SIZE,
   parameter int MAX_Y        = V_ACTIVE - FROG_SIZE,
   parameter int START_X      = DEF_START_X,
   parameter int START_Y      = DEF_START_Y,
   parameter int HOP_COOLDOWN = 8,
   parameter int DEATH_FRAMES = 60
) (
   input  logic              clk,
   input  logic              rst,
   frog_controller_if.slave  bus
);

   localparam int               CNT_W      = 8;
   localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(HOP_COOLDOWN - 1);
   localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_FRAMES - 1);

   logic             rise_up;
   logic             rise_down;
   logic             rise_left;
   logic             rise_right;
   logic             any_rise;
   dir_t             new_dir;
   dir_t             pend_dir;
   frog_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [9:0]       pos_x;
   logic [9:0]       pos_y;
   logic [9:0]       nxt_x;
   logic [9:0]       nxt_y;
   logic             hop_q;
   logic             row_q;
   logic             dead_q;

   button_edge u_edge_up    (.clk(clk), .rst(rst), .btn_in(bus.btn_up),    .btn_rise(rise_up));
   button_edge u_edge_down  (.clk(clk), .rst(rst), .btn_in(bus.btn_down),  .btn_rise(rise_down));
   button_edge u_edge_left  (.clk(clk), .rst(rst), .btn_in(bus.btn_left),  .btn_rise(rise_left));
   button_edge u_edge_right (.clk(clk), .rst(rst), .btn_in(bus.btn_right), .btn_rise(rise_right));

   assign any_rise = rise_up | rise_down | rise_left | rise_right;
   assign new_dir  = dir_prio(rise_up, rise_down, rise_left, rise_right);

   // Legality is judged on the current position; widened so the sum cannot wrap.
   function automatic logic move_legal(input dir_t d, input logic [9:0] x,
                                       input logic [9:0] y);
      logic [10:0] xe;
      logic [10:0] ye;
      xe = {1'b0, x};
      ye = {1'b0, y};
      case (d)
         DIR_UP:    return ye >= 11'(STEP);
         DIR_DOWN:  return (ye + 11'(STEP)) <= 11'(MAX_Y);
         DIR_LEFT:  return xe >= 11'(STEP);
         DIR_RIGHT: return (xe + 11'(STEP)) <= 11'(MAX_X);
         default:   return 1'b0;
      endcase
   endfunction

   always_comb begin
      nxt_x = pos_x;
      nxt_y = pos_y;
      case (pend_dir)
         DIR_UP:    nxt_y = pos_y - 10'(STEP);
         DIR_DOWN:  nxt_y = pos_y + 10'(STEP);
         DIR_LEFT:  nxt_x = pos_x - 10'(STEP);
         DIR_RIGHT: nxt_x = pos_x + 10'(STEP);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         pend_dir <= DIR_NONE;
         pos_x    <= 10'(START_X);
         pos_y    <= 10'(START_Y);
         hop_q    <= 1'b0;
         row_q    <= 1'b0;
         dead_q   <= 1'b0;
      end else begin
         hop_q <= 1'b0;
         row_q <= 1'b0;

         // An edge coincident with the tick survives into the next frame.
         if (any_rise && state != ST_DEAD)
            pend_dir <= new_dir;
         else if (bus.frame_tick)
            pend_dir <= DIR_NONE;

         if (bus.frame_tick) begin
            unique case (state)
               ST_IDLE: begin
                  if (bus.collision) begin
                     state  <= ST_DEAD;
                     cnt    <= DEATH_LOAD;
                     dead_q <= 1'b1;
                  end else if (pend_dir != DIR_NONE && move_legal(pend_dir, pos_x, pos_y)) begin
                     pos_x <= nxt_x;
                     pos_y <= nxt_y;
                     hop_q <= 1'b1;
                     row_q <= (pend_dir == DIR_UP);
                     state <= ST_COOLDOWN;
                     cnt   <= COOL_LOAD;
                  end
               end
               ST_COOLDOWN: begin
                  if (bus.collision) begin
                     state  <= ST_DEAD;
                     cnt    <= DEATH_LOAD;
                     dead_q <= 1'b1;
                  end else if (cnt == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_DEAD: begin
                  if (cnt == '0) begin
                     state  <= ST_IDLE;
                     pos_x  <= 10'(START_X);
                     pos_y  <= 10'(START_Y);
                     dead_q <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.frog_x      = pos_x;
   assign bus.frog_y      = pos_y;
   assign bus.hop_pulse   = hop_q;
   assign bus.row_advance = row_q;
   assign bus.dead        = dead_q;

endmodule

// File: tb/tb_frog_controller.sv
// Bench for frog_controller: directed scenarios plus random buttons/ticks/
// collisions, every cycle compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_frog_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   frog_controller_if fif ();

   frog_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (fif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position, frames left dead/cooling (-1 = not),
   // pending direction (0 none, 1 up, 2 down, 3 left, 4 right).
   int m_x, m_y, m_dead_left, m_cool_left, m_pend, m_hop, m_row;
   bit hist [4][3];   // per button: levels seen 1, 2 and 3 edges ago

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit cur [4];
      bit rise [4];
      bit was_dead;
      bit any;
      int dir, nx, ny;
      cur[0] = fif.btn_up;
      cur[1] = fif.btn_down;
      cur[2] = fif.btn_left;
      cur[3] = fif.btn_right;
      m_hop = 0;
      m_row = 0;
      if (rst) begin
         m_x = 320; m_y = 448; m_dead_left = -1; m_cool_left = -1; m_pend = 0;
         for (int b = 0; b < 4; b++)
            for (int k = 0; k < 3; k++) hist[b][k] = 1'b0;
         return;
      end
      // A press seen at edge n becomes a request two edges later.
      for (int b = 0; b < 4; b++) rise[b] = hist[b][1] && !hist[b][2];
      was_dead = (m_dead_left >= 0);
      if (fif.frame_tick) begin
         if (m_dead_left >= 0) begin
            if (m_dead_left == 0) begin
               m_x = 320; m_y = 448; m_dead_left = -1;
            end else m_dead_left--;
         end else if (fif.collision) begin
            m_dead_left = 59; m_cool_left = -1;
         end else if (m_cool_left >= 0) begin
            m_cool_left--;
         end else if (m_pend != 0) begin
            nx = m_x; ny = m_y;
            case (m_pend)
               1: ny = m_y - 32;
               2: ny = m_y + 32;
               3: nx = m_x - 32;
               default: nx = m_x + 32;
            endcase
            if (nx >= 0 && nx <= 608 && ny >= 0 && ny <= 448) begin
               m_x = nx; m_y = ny; m_hop = 1; m_row = (m_pend == 1); m_cool_left = 7;
            end
         end
      end
      any = 0; dir = 0;
      for (int b = 3; b >= 0; b--)
         if (rise[b]) begin any = 1; dir = b + 1; end
      if (any && !was_dead) m_pend = dir;
      else if (fif.frame_tick) m_pend = 0;
      for (int b = 0; b < 4; b++) begin
         hist[b][2] = hist[b][1];
         hist[b][1] = hist[b][0];
         hist[b][0] = cur[b];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("frog_x", int'(fif.frog_x), m_x);
      check("frog_y", int'(fif.frog_y), m_y);
      check("hop_pulse", int'(fif.hop_pulse), m_hop);
      check("row_advance", int'(fif.row_advance), m_row);
      check("dead", int'(fif.dead), (m_dead_left >= 0) ? 1 : 0);
   endtask

   task automatic tick();
      repeat (3) cyc();
      fif.frame_tick = 1'b1;
      cyc();
      fif.frame_tick = 1'b0;
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: fif.btn_up = v;
         1: fif.btn_down = v;
         2: fif.btn_left = v;
         default: fif.btn_right = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      repeat (3) cyc();
      set_btn(b, 1'b0);
      repeat (2) cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      fif.btn_up = 0; fif.btn_down = 0; fif.btn_left = 0; fif.btn_right = 0;
      fif.frame_tick = 0; fif.collision = 0;
      rst = 1'b1;

      // reset values and idle frames
      do_reset();
      check("rst_x", int'(fif.frog_x), 320);
      check("rst_y", int'(fif.frog_y), 448);
      check("rst_dead", int'(fif.dead), 0);
      check("rst_hop", int'(fif.hop_pulse), 0);
      repeat (5) tick();
      check("idle_x", int'(fif.frog_x), 320);
      check("idle_y", int'(fif.frog_y), 448);

      // held up button: exactly one hop
      fif.btn_up = 1'b1;
      repeat (1000) cyc();
      fif.frame_tick = 1'b1;
      cyc();
      fif.frame_tick = 1'b0;
      check("up_y", int'(fif.frog_y), 416);
      check("up_hop", int'(fif.hop_pulse), 1);
      check("up_row", int'(fif.row_advance), 1);
      cyc();
      check("up_hop_1cyc", int'(fif.hop_pulse), 0);
      check("up_row_1cyc", int'(fif.row_advance), 0);
      repeat (10) tick();
      check("held_no_rehop", int'(fif.frog_y), 416);
      fif.btn_up = 1'b0;
      repeat (3) cyc();

      // cooldown refuses hops for 8 frames
      press(3);
      tick();
      check("cd_first", int'(fif.frog_x), 352);
      for (int k = 0; k < 7; k++) begin
         press(3);
         tick();
      end
      check("cd_blocked", int'(fif.frog_x), 352);
      press(3);
      tick();
      press(3);
      tick();
      check("cd_released", int'(fif.frog_x), 384);

      // boundaries
      do_reset();
      press(1);
      tick();
      check("down_clamp_y", int'(fif.frog_y), 448);
      check("down_clamp_hop", int'(fif.hop_pulse), 0);
      for (int k = 0; k < 10; k++) begin
         press(2);
         tick();
         check("left_hop", int'(fif.hop_pulse), 1);
         repeat (8) tick();
      end
      check("left_edge_x", int'(fif.frog_x), 0);
      press(2);
      tick();
      check("left_clamp_x", int'(fif.frog_x), 0);
      check("left_clamp_hop", int'(fif.hop_pulse), 0);

      // simultaneous presses, then an edge landing on the tick
      do_reset();
      fif.btn_up = 1'b1; fif.btn_right = 1'b1;
      repeat (3) cyc();
      fif.btn_up = 1'b0; fif.btn_right = 1'b0;
      repeat (2) cyc();
      tick();
      check("simul_y", int'(fif.frog_y), 416);
      check("simul_x", int'(fif.frog_x), 320);
      repeat (8) tick();
      fif.btn_left = 1'b1;
      cyc();
      cyc();
      fif.frame_tick = 1'b1;
      cyc();
      fif.frame_tick = 1'b0;
      check("edge_on_tick_now", int'(fif.frog_x), 320);
      fif.btn_left = 1'b0;
      tick();
      check("edge_on_tick_next", int'(fif.frog_x), 288);

      // death and respawn
      do_reset();
      press(3); tick(); repeat (8) tick();
      press(0); tick(); repeat (8) tick();
      press(0);
      fif.collision = 1'b1;
      fif.frame_tick = 1'b1;
      cyc();
      fif.frame_tick = 1'b0;
      fif.collision = 1'b0;
      check("death_dead", int'(fif.dead), 1);
      check("death_x", int'(fif.frog_x), 352);
      check("death_y", int'(fif.frog_y), 416);
      press(0);
      repeat (59) tick();
      check("dead_59", int'(fif.dead), 1);
      check("dead_59_y", int'(fif.frog_y), 416);
      tick();
      check("respawn_dead", int'(fif.dead), 0);
      check("respawn_x", int'(fif.frog_x), 320);
      check("respawn_y", int'(fif.frog_y), 448);
      check("respawn_hop", int'(fif.hop_pulse), 0);
      press(3); tick(); repeat (8) tick();
      fif.collision = 1'b1;
      tick();
      fif.collision = 1'b0;
      repeat (5) tick();
      check("middeath_dead", int'(fif.dead), 1);
      rst = 1'b1;
      cyc();
      check("middeath_rst_dead", int'(fif.dead), 0);
      check("middeath_rst_x", int'(fif.frog_x), 320);
      check("middeath_rst_y", int'(fif.frog_y), 448);
      rst = 1'b0;
      cyc();

      // random buttons, ticks, collisions and occasional reset
      repeat (6000) begin
         if ($urandom_range(0, 15) == 0) fif.btn_up    = ~fif.btn_up;
         if ($urandom_range(0, 15) == 0) fif.btn_down  = ~fif.btn_down;
         if ($urandom_range(0, 15) == 0) fif.btn_left  = ~fif.btn_left;
         if ($urandom_range(0, 15) == 0) fif.btn_right = ~fif.btn_right;
         if ($urandom_range(0, 99) == 0) fif.collision = ~fif.collision;
         fif.frame_tick = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 1999) == 0);
         cyc();
      end
      rst = 1'b0;
      fif.frame_tick = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
